// File: rtl/z2_bus_cycle.sv
// Zorro II slave bus-cycle sequencer.
// Synchronises the 68000 strobes, sequences IDLE/START/DATA/END for cycles
// addressed to this card, merges slave acknowledges into one DTACK drive,
// owns the data-bus output enable and abandons cycles nobody acknowledges.
module z2_bus_cycle #(
  parameter int TIMEOUT_CYCLES = 32,  // CLKs in Z2_DATA before giving up (2..255)
  parameter int SYNC_STAGES    = 2    // synchroniser depth (2 or 3)
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       match,
  input  logic       ack_in,
  output logic [1:0] z2_state,
  output logic       dtack_oe,
  output logic       data_oe,
  output logic       rw_l,
  output logic       timeout
);

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'b00,
    Z2_START = 2'b01,
    Z2_DATA  = 2'b10,
    Z2_END   = 2'b11
  } z2_state_e;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] LP_CNT_MAX  = 8'hFF;

  logic [SYNC_STAGES-1:0] r_as_sync;
  logic [SYNC_STAGES-1:0] r_uds_sync;
  logic [SYNC_STAGES-1:0] r_lds_sync;

  z2_state_e  r_state;
  logic [7:0] r_cnt;
  logic       r_ignore;
  logic       r_rw_l;
  logic       r_dtack_oe;
  logic       r_data_oe;
  logic       r_timeout;

  z2_state_e  w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_ignore_nxt;
  logic       w_rw_l_nxt;
  logic       w_dtack_nxt;
  logic       w_data_oe_nxt;
  logic       w_timeout_nxt;
  logic       w_as_s;
  logic       w_ds_s;

  // Shift the asynchronous strobes through the synchroniser chains.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      // NOTE: the chains reset to the deasserted (high) strobe level so a
      // strobe already low at reset release is seen as a fresh falling edge.
      r_as_sync  <= '1;
      r_uds_sync <= '1;
      r_lds_sync <= '1;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the value
      // its neighbour held before the edge; blocking here would collapse the chain.
      r_as_sync  <= {r_as_sync[SYNC_STAGES-2:0], AS_n};
      r_uds_sync <= {r_uds_sync[SYNC_STAGES-2:0], UDS_n};
      r_lds_sync <= {r_lds_sync[SYNC_STAGES-2:0], LDS_n};
    end
  end

  assign w_as_s = ~r_as_sync[SYNC_STAGES-1];
  assign w_ds_s = ~r_uds_sync[SYNC_STAGES-1] | ~r_lds_sync[SYNC_STAGES-1];

  // Next-state and registered-output decode for the bus-cycle sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ignore_nxt  = r_ignore;
    w_rw_l_nxt    = r_rw_l;
    w_dtack_nxt   = r_dtack_oe;
    w_timeout_nxt = 1'b0;

    case (r_state)
      Z2_IDLE: begin
        w_dtack_nxt = 1'b0;
        if (!w_as_s) begin
          w_ignore_nxt = 1'b0;
        end else if (!r_ignore) begin
          if (match) begin
            w_state_nxt = Z2_START;
            w_rw_l_nxt  = RW;
          end else begin
            // Not ours: sit this whole cycle out even if match rises later.
            w_ignore_nxt = 1'b1;
          end
        end
      end

      Z2_START: begin
        if (!w_as_s) begin
          w_state_nxt = Z2_IDLE;
        end else if (w_ds_s) begin
          w_state_nxt = Z2_DATA;
          w_cnt_nxt   = '0;
        end
      end

      Z2_DATA: begin
        if (!w_as_s) begin
          w_state_nxt = Z2_IDLE;
        end else if (ack_in) begin
          // Acknowledge beats a simultaneous terminal count.
          w_state_nxt = Z2_END;
          w_dtack_nxt = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt   = Z2_END;
          w_timeout_nxt = 1'b1;
        end else if (r_cnt != LP_CNT_MAX) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      Z2_END: begin
        // Late acknowledges are ignored; wait for the master to end the cycle.
        if (!w_as_s) begin
          w_state_nxt = Z2_IDLE;
          w_dtack_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = Z2_IDLE;
        w_dtack_nxt = 1'b0;
      end
    endcase

    // Drive the data bus only for our read cycles while the strobe is held.
    w_data_oe_nxt = ((w_state_nxt == Z2_DATA) || (w_state_nxt == Z2_END))
                    && w_rw_l_nxt && w_as_s;
  end

  // Register state, counter and all bus-facing outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= Z2_IDLE;
      r_cnt      <= '0;
      r_ignore   <= 1'b0;
      r_rw_l     <= 1'b1;
      r_dtack_oe <= 1'b0;
      r_data_oe  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ignore   <= w_ignore_nxt;
      r_rw_l     <= w_rw_l_nxt;
      r_dtack_oe <= w_dtack_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign z2_state = r_state;
  assign dtack_oe = r_dtack_oe;
  assign data_oe  = r_data_oe;
  assign rw_l     = r_rw_l;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_z2_bus_cycle.sv
// Self-checking bench for z2_bus_cycle: directed and random bus cycles, a
// transaction-level prediction queue and a monitor that scores each cycle.
module tb_z2_bus_cycle;

  localparam int TO = 32;
  localparam int SS = 2;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_START = 2'b01;
  localparam logic [1:0] S_DATA  = 2'b10;
  localparam logic [1:0] S_END   = 2'b11;

  typedef enum int {K_ACK, K_TO, K_AB_START, K_AB_DATA} kind_e;
  typedef struct {
    kind_e kind;
    logic  rw;
    int    ev_k;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET_n, AS_n, UDS_n, LDS_n, RW, match, ack_in;
  logic [1:0] z2_state;
  logic       dtack_oe, data_oe, rw_l, timeout;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   mon_en   = 1'b0;

  always #5 CLK = ~CLK;

  z2_bus_cycle #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW(RW), .match(match), .ack_in(ack_in), .z2_state(z2_state),
    .dtack_oe(dtack_oe), .data_oe(data_oe), .rw_l(rw_l), .timeout(timeout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, $signed(act), $signed(req));
    end
  endtask

  // Reference model: outcome of a data-phase cycle from the acknowledge delay.
  // The acknowledge is sampled d+1 CLKs into Z2_DATA; the cycle is abandoned
  // TO CLKs in, and an acknowledge on that same edge still wins.
  function automatic exp_t predict(input logic rw, input int ack_d);
    exp_t e;
    e.rw = rw;
    if (ack_d >= 0 && ack_d + 1 <= TO) begin
      e.kind = K_ACK;
      e.ev_k = ack_d + 1;
    end else begin
      e.kind = K_TO;
      e.ev_k = TO;
    end
    return e;
  endfunction

  function automatic logic [15:0] exp_seq(input kind_e k);
    case (k)
      K_AB_START: return 16'h0004;  // 00 01 00
      K_AB_DATA:  return 16'h0018;  // 00 01 10 00
      default:    return 16'h006C;  // 00 01 10 11 00
    endcase
  endfunction

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK); #1;
      if (z2_state == s) seen = 1'b1;
    end
    if (!seen) check({"wait_", nm}, 32'(z2_state), 32'(s));
  endtask

  // cls: 0 data phase, 1 abort in START, 2 abort in DATA, 3 not our address
  task automatic do_cycle(input int cls, input logic rw, input int ack_d,
                          input bit level, input int hold, input int gap);
    exp_t e;
    bit   use_u, use_l;
    use_u = $urandom_range(0, 1);
    use_l = !use_u || ($urandom_range(0, 3) == 0);
    if (cls == 0) exp_q.push_back(predict(rw, ack_d));
    if (cls == 1) begin e.kind = K_AB_START; e.rw = rw; e.ev_k = -1; exp_q.push_back(e); end
    if (cls == 2) begin e.kind = K_AB_DATA;  e.rw = rw; e.ev_k = -1; exp_q.push_back(e); end

    RW    = rw;
    match = (cls != 3);
    AS_n  = 1'b0;
    wait_state(S_IDLE, 8, "idle");
    if (cls == 0 || cls == 2) begin
      UDS_n = !use_u;
      LDS_n = !use_l;
    end
    case (cls)
      0: begin
        wait_state(S_DATA, 12, "data");
        match = $urandom_range(0, 1);
        if (ack_d >= 0) begin
          repeat (ack_d) begin @(posedge CLK); #1; end
          ack_in = 1'b1;
          if (!level) begin @(posedge CLK); #1; ack_in = 1'b0; end
        end
        wait_state(S_END, TO + 8, "end");
        repeat (hold) begin @(posedge CLK); #1; end
      end
      1: wait_state(S_START, 12, "start");
      2: begin
        wait_state(S_DATA, 12, "data");
        repeat (2) begin @(posedge CLK); #1; end
      end
      default: begin
        repeat (4) begin @(posedge CLK); #1; end
        match = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
      end
    endcase
    AS_n   = 1'b1;
    UDS_n  = 1'b1;
    LDS_n  = 1'b1;
    ack_in = 1'b0;
    match  = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  // Monitor: scores each non-idle excursion of z2_state against the queue.
  bit          in_cyc = 1'b0, have_exp = 1'b0, hi_started;
  exp_t        cur;
  logic [15:0] seq;
  logic [1:0]  last_st;
  int          k, first_dt, to_cnt, to_k, dt_bad, doe_bad, hi_cnt;
  logic        rw_seen;

  always @(negedge CLK) begin
    if (!mon_en) begin
      in_cyc = 1'b0;
    end else begin
      if (!in_cyc && z2_state != S_IDLE) begin
        in_cyc = 1'b1;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          checks++;
          failures++;
          $display("FAIL unexpected_cycle: actual state=%0d required=0", z2_state);
        end else begin
          cur      = exp_q.pop_front();
          have_exp = 1'b1;
        end
        seq = 16'h0000; last_st = S_IDLE; k = -1; first_dt = -1;
        to_cnt = 0; to_k = -1; dt_bad = 0; doe_bad = 0; hi_cnt = 0;
        hi_started = 1'b0; rw_seen = rw_l;
      end
      if (in_cyc) begin
        if (z2_state != last_st) begin
          seq     = {seq[13:0], z2_state};
          last_st = z2_state;
        end
        if (k >= 0) k++;
        else if (z2_state == S_DATA) k = 0;
        if (dtack_oe && first_dt < 0) first_dt = k;
        if (timeout) begin to_cnt++; to_k = k; end
        if (have_exp) begin
          if (dtack_oe !== (z2_state == S_END && cur.kind == K_ACK)) dt_bad++;
          if (data_oe !== ((z2_state == S_DATA || z2_state == S_END) && cur.rw)) doe_bad++;
        end
        if (z2_state == S_IDLE) begin
          in_cyc = 1'b0;
          if (have_exp) begin
            check("state_seq", 32'(seq), 32'(exp_seq(cur.kind)));
            check("dtack_first_clk", first_dt, (cur.kind == K_ACK) ? cur.ev_k : -1);
            check("timeout_pulses", to_cnt, (cur.kind == K_TO) ? 1 : 0);
            if (cur.kind == K_TO) check("timeout_clk", to_k, cur.ev_k);
            check("dtack_level_errs", dt_bad, 0);
            check("data_oe_errs", doe_bad, 0);
            check("rw_l", 32'(rw_seen), 32'(cur.rw));
            check("as_release_clks", hi_cnt, SS + 1);
          end
        end else if (AS_n || hi_started) begin
          hi_started = 1'b1;
          hi_cnt++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_opts[10] = '{0, 1, 2, 3, 4, 5, 30, 31, 32, -1};
    int n;
    bit seen;

    // Reset held while a matching cycle is already on the bus.
    RESET_n = 1'b0; AS_n = 1'b0; match = 1'b1; RW = 1'b0;
    UDS_n = 1'b1; LDS_n = 1'b1; ack_in = 1'b0;
    #23;
    check("rst_state", 32'(z2_state), 0);
    check("rst_dtack", 32'(dtack_oe), 0);
    check("rst_data_oe", 32'(data_oe), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_rw_l", 32'(rw_l), 1);
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge CLK); #1;
      if (z2_state == S_START) begin n = i; seen = 1'b1; end
    end
    check("rst_release_to_start", n, SS + 1);
    AS_n = 1'b1; match = 1'b0;
    wait_state(S_IDLE, 8, "rst_idle");
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;

    // Directed cycles.
    do_cycle(0, 1'b1, 3, 1'b0, 1, 1);    // read, ack pulse 3 CLKs into DATA
    do_cycle(0, 1'b1, 2, 1'b0, 0, 1);    // back-to-back read
    do_cycle(0, 1'b0, 2, 1'b1, 1, 2);    // write, level ack
    do_cycle(0, 1'b1, -1, 1'b0, 1, 3);   // no ack: timeout
    do_cycle(3, 1'b1, 0, 1'b0, 0, 1);    // not our address, match rises late
    do_cycle(1, 1'b1, 0, 1'b0, 0, 2);    // abort in START
    do_cycle(0, 1'b1, 31, 1'b0, 0, 1);   // ack on terminal count
    do_cycle(2, 1'b0, 0, 1'b0, 0, 1);    // abort in DATA
    do_cycle(0, 1'b0, 32, 1'b1, 2, 1);   // ack after abandon: ignored

    // Random cycles.
    for (int c = 0; c < 30; c++) begin
      int r = $urandom_range(0, 11);
      int cls = (r == 0) ? 3 : (r == 1) ? 1 : (r == 2) ? 2 : 0;
      do_cycle(cls, logic'($urandom_range(0, 1)), ack_opts[$urandom_range(0, 9)],
               bit'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 3));
    end

    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0 && !in_cyc) seen = 1'b1;
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset asserted mid-cycle with DTACK driven.
    mon_en = 1'b0;
    RW = 1'b1; match = 1'b1; AS_n = 1'b0;
    wait_state(S_START, 8, "mid_start");
    UDS_n = 1'b0;
    wait_state(S_DATA, 8, "mid_data");
    ack_in = 1'b1;
    @(posedge CLK); #1;
    ack_in = 1'b0;
    check("mid_pre_dtack", 32'(dtack_oe), 1);
    check("mid_pre_data_oe", 32'(data_oe), 1);
    #3;
    RESET_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(z2_state), 0);
    check("mid_rst_dtack", 32'(dtack_oe), 0);
    check("mid_rst_data_oe", 32'(data_oe), 0);
    check("mid_rst_rw_l", 32'(rw_l), 1);
    AS_n = 1'b1; UDS_n = 1'b1; match = 1'b0;
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    mon_en = 1'b1;
    do_cycle(0, 1'b1, 1, 1'b0, 0, 2);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0 && !in_cyc) seen = 1'b1;
    end
    check("post_rst_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z2_bus_cycle.md
Name: z2_bus_cycle

Overview:
- Zorro II slave bus-cycle sequencer that produces `z2_state[1:0]`.
- `z2_state` is consumed by the Autoconfig block, which acts only in Z2_DATA, and by the RAM, IDE and control slaves.
- Synchronises the asynchronous 68000 strobes, gates cycles on a decoded "our access" match, and merges slave acknowledges into one bus DTACK drive.
- Owns data-bus output enable and the no-acknowledge timeout.

Parameters:
- TIMEOUT_CYCLES, 32: CLK cycles spent in Z2_DATA without `ack_in` before the cycle is abandoned; legal range 2..255.
- SYNC_STAGES, 2: flip-flop stages on AS_n, UDS_n and LDS_n; legal values 2 or 3.

Ports:
- CLK  in  1  bus-domain clock (7.09/7.16 MHz or a multiple).
- RESET_n  in  1  reset, asynchronous, active-low.
- AS_n  in  1  68000 address strobe, asynchronous.
- UDS_n  in  1  upper data strobe, asynchronous.
- LDS_n  in  1  lower data strobe, asynchronous.
- RW  in  1  bus read(1)/write(0).
- match  in  1  OR of `autoconfig_cycle`, `ram_access`, `ide_access`, `ctrl_access`, `flash_access`.
- ack_in  in  1  OR of slave dtack outputs; level or pulse.
- z2_state  out  2  Z2_IDLE=2'b00, Z2_START=2'b01, Z2_DATA=2'b10, Z2_END=2'b11.
- dtack_oe  out  1  1 = drive bus DTACK_n low.
- data_oe  out  1  1 = drive data bus (our read cycle).
- rw_l  out  1  RW latched at cycle start.
- timeout  out  1  one-CLK pulse when a cycle is abandoned.

Behaviour:
- **Reset:** RESET_n low forces, asynchronously:
  - `z2_state`=Z2_IDLE; `dtack_oe`, `data_oe`, `timeout`=0; `rw_l`=1.
  - Sync chains set to the deasserted value (1); timeout counter=0.
- **Synchronisers:**
  - `as_s` = AS_n low at the last sync stage.
  - `ds_s` = UDS_n or LDS_n low at the last sync stage.
  - Latency from AS_n falling to `as_s` is SYNC_STAGES CLKs.
- **Z2_IDLE:**
  - `as_s` and `match` -> Z2_START; `rw_l` <= RW.
  - `as_s` without `match` -> stay in Z2_IDLE, ignoring this cycle until `as_s` drops.
  - The ignore flag clears when `as_s` = 0.
- **Z2_START:**
  - `ds_s` -> Z2_DATA; counter <= 0.
  - `!as_s` -> Z2_IDLE (aborted cycle, no dtack).
- **Z2_DATA:**
  - Priority: `!as_s` > `ack_in` > timeout.
  - `!as_s` -> Z2_IDLE.
  - `ack_in` -> Z2_END; `dtack_oe` <= 1 registered, asserted the CLK after `ack_in` is sampled.
  - Counter reaches TIMEOUT_CYCLES-1 without `ack_in` -> Z2_END with `dtack_oe`=0 and `timeout`=1 for one CLK.
  - Counter saturates and does not wrap.
- **Z2_END:**
  - Hold `dtack_oe` (stays 0 after a timeout) until `!as_s`.
  - Then -> Z2_IDLE with `dtack_oe` <= 0 on the same edge.
  - `ack_in` is ignored in this state.
- **data_oe:**
  - Asserted = (state==Z2_DATA or Z2_END) and `rw_l`=1 and `as_s`.
  - Registered, so it drops the CLK after `as_s` drops.
  - Never asserted on write cycles.
- **Back-to-back cycles:** Z2_END must pass through Z2_IDLE; a new cycle is recognised only after `as_s` has been seen deasserted for at least one CLK.
- **Simultaneous `ack_in` and counter terminal value:** `ack_in` wins; no `timeout` pulse.
- **`match` dropping mid-cycle:** ignored; address is stable while AS_n is low.
- **Reset mid-cycle:** all outputs drop immediately; the following cycle starts clean from Z2_IDLE.

Test Plan:
- **Reset:** hold RESET_n=0 while AS_n=0 and `match`=1 -> `z2_state`=00 and all outputs 0; release -> Z2_START after SYNC_STAGES+1 CLKs.
- **Read cycle:** AS_n low, RW=1, `match`=1, UDS_n low 1 CLK later, `ack_in` pulse 3 CLKs into Z2_DATA ->
  - state sequence 00,01,10,11;
  - `dtack_oe`=1 from the CLK after `ack_in`;
  - `data_oe`=1 in Z2_DATA and Z2_END;
  - AS_n high -> both 0 and state 00 within SYNC_STAGES+1 CLKs.
- **Write cycle:** RW=0, LDS_n low -> `data_oe` never 1; `dtack_oe` asserted after `ack_in`; `rw_l`=0.
- **Timeout:** TIMEOUT_CYCLES=32, no `ack_in` -> `timeout` pulses exactly once, 32 CLKs after entering Z2_DATA; `dtack_oe` stays 0; state 11 until AS_n high.
- **Non-matching and aborted cycles:**
  - `match`=0 -> state stays 00.
  - AS_n rises while in Z2_START -> 00 with no `dtack_oe`.
  - `ack_in` coincident with the counter terminal value -> `dtack_oe`=1, `timeout`=0.
- **Back-to-back:** two read cycles with AS_n high for only 1 CLK between them -> two complete 00-01-10-11 sequences and two separate `dtack_oe` assertions.
